// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional macro MULDIV_DIVZERO_EN: early divide-by-zero exit plus divzero flag.
module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_EN
   ,
   output logic             divzero
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     counter;
   logic [WIDTH-1:0]  acc_hi, acc_lo, opb;
   logic              is_div_q, neg_q, neg_r;
   logic              last, launch, launch_calc, fix_en;

   // operand sign handling: signed ops work on magnitudes
   logic              is_signed, a_neg, b_neg;
   logic [WIDTH-1:0]  a_mag, b_mag;
   assign is_signed = ~op[0];
   assign a_neg     = is_signed & srca[WIDTH-1];
   assign b_neg     = is_signed & srcb[WIDTH-1];
   assign a_mag     = a_neg ? -srca : srca;
   assign b_mag     = b_neg ? -srcb : srcb;

   assign last   = (counter == CW'(WIDTH-1));
   assign launch = start & ~flush & (state_q == IDLE);

`ifdef MULDIV_DIVZERO_EN
   logic dz;
   assign dz          = launch & op[1] & (srcb == '0);
   assign launch_calc = launch & ~dz;
`else
   assign launch_calc = launch;
`endif

   // one shift-add step and one restoring shift-subtract step
   logic [WIDTH:0]    mul_sum, div_sh;
   logic [WIDTH-1:0]  div_diff;
   logic              div_ge;
   assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
   assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
   assign div_ge   = (div_sh >= {1'b0, opb});
   assign div_diff = div_sh[WIDTH-1:0] - opb;

   // final sign correction
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   assign prod     = {acc_hi, acc_lo};
   assign prod_fix = neg_q ? -prod : prod;
   assign quo_fix  = neg_q ? -acc_lo : acc_lo;
   assign rem_fix  = neg_r ? -acc_hi : acc_hi;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next state and status decode; flush always returns to IDLE
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      fix_en  = 1'b0;
      unique case (state_q)
         IDLE: if (launch_calc) state_d = CALC;
         CALC: begin
            busy = 1'b1;
            if (last) state_d = FIX;
         end
         FIX: begin
            busy    = 1'b1;
            fix_en  = ~flush;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // iteration datapath: operand latch and per-cycle step
   always_ff @(posedge clk) begin
      if (reset) begin
         counter  <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opb      <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else if (launch_calc) begin
         counter  <= '0;
         acc_hi   <= '0;
         acc_lo   <= op[1] ? a_mag : b_mag;
         opb      <= op[1] ? b_mag : a_mag;
         is_div_q <= op[1];
         neg_q    <= a_neg ^ b_neg;
         neg_r    <= a_neg;
      end else if (state_q == CALC) begin
         counter <= last ? '0 : counter + 1'b1;
         if (is_div_q) begin
            acc_hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
         end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
         end
      end
   end

   // HI/LO writeback, done pulse and MTHI/MTLO
   always_ff @(posedge clk) begin
      if (reset) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
         divzero <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
         divzero <= 1'b0;
`endif
         if (fix_en) begin
            done <= 1'b1;
            if (is_div_q) begin
               hi <= rem_fix;
               lo <= quo_fix;
            end else begin
               hi <= prod_fix[2*WIDTH-1:WIDTH];
               lo <= prod_fix[WIDTH-1:0];
            end
`ifdef MULDIV_DIVZERO_EN
         end else if (dz) begin
            hi      <= srca;
            lo      <= '0;
            done    <= 1'b1;
            divzero <= 1'b1;
`endif
         end else if (state_q == IDLE && !start && !flush) begin
            if (wr_hi) hi <= srca;
            if (wr_lo) lo <= srca;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed table vectors plus multi-cycle corner sequences.
// Build with or without MULDIV_DIVZERO_EN.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, wr_hi, wr_lo, flush;
   logic [1:0]  op;
   logic [31:0] srca, srcb;
   logic        busy, done, dz;
   logic [31:0] hi, lo;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .srca   (srca),
      .srcb   (srcb),
      .wr_hi  (wr_hi),
      .wr_lo  (wr_lo),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
`ifdef MULDIV_DIVZERO_EN
      ,
      .divzero(dz)
`endif
   );

`ifndef MULDIV_DIVZERO_EN
   assign dz = 1'b0;
`endif

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   typedef struct {
      string       nm;
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      int          lat, busy_n;
      logic        dz;
   } vec_t;

   vec_t vecs[11];

   // launch one op and observe up to 45 cycles
   task automatic run(input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input int dist_at,
                      input bit dist_flush, input bit stop,
                      output int done_at, output int busy_n,
                      output int dones, output logic [31:0] rhi,
                      output logic [31:0] rlo, output logic rdz);
      done_at = -1; busy_n = 0; dones = 0;
      rhi = hi; rlo = lo; rdz = 1'b0;
      op = o; srca = a; srcb = b; start = 1'b1;
      for (int i = 1; i <= 45; i++) begin
         @(posedge clk); #1;
         if (i == 1) start = 1'b0;
         if (busy) busy_n++;
         if (done) begin
            dones++;
            if (done_at < 0) begin
               done_at = i; rhi = hi; rlo = lo; rdz = dz;
            end
         end
         if (i == dist_at) begin
            if (dist_flush) flush = 1'b1;
            else begin
               start = 1'b1; op = 2'b01; srca = 3; srcb = 3;
            end
         end else if (i == dist_at + 1) begin
            flush = 1'b0; start = 1'b0;
         end
         if (stop && done) break;
      end
   endtask

   task automatic count_done(input int n, output int dones);
      dones = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
   endtask

   initial begin
      int          at, bn, dn;
      logic [31:0] rh, rl;
      logic        rz;

      vecs[0]  = '{"multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFE, 32'h00000001, 34, 33, 1'b0};
      vecs[1]  = '{"mult_m7x3", 2'b00, 32'hFFFFFFF9, 32'd3,
                   32'hFFFFFFFF, 32'hFFFFFFEB, 34, 33, 1'b0};
      vecs[2]  = '{"divu_100_7", 2'b11, 32'd100, 32'd7,
                   32'd2, 32'd14, 34, 33, 1'b0};
      vecs[3]  = '{"div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF,
                   32'd0, 32'h80000000, 34, 33, 1'b0};
      vecs[4]  = '{"div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE,
                   32'd1, 32'hFFFFFFFD, 34, 33, 1'b0};
      vecs[5]  = '{"mult_min_min", 2'b00, 32'h80000000, 32'h80000000,
                   32'h40000000, 32'd0, 34, 33, 1'b0};
      vecs[6]  = '{"multu_shift", 2'b01, 32'h12345678, 32'h10,
                   32'd1, 32'h23456780, 34, 33, 1'b0};
      vecs[7]  = '{"mult_min_x1", 2'b00, 32'h80000000, 32'd1,
                   32'hFFFFFFFF, 32'h80000000, 34, 33, 1'b0};
      vecs[8]  = '{"div_m20_m6", 2'b10, 32'hFFFFFFEC, 32'hFFFFFFFA,
                   32'hFFFFFFFE, 32'd3, 34, 33, 1'b0};
`ifdef MULDIV_DIVZERO_EN
      vecs[9]  = '{"divu_9_0", 2'b11, 32'd9, 32'd0,
                   32'd9, 32'd0, 1, 0, 1'b1};
      vecs[10] = '{"div_m9_0", 2'b10, 32'hFFFFFFF7, 32'd0,
                   32'hFFFFFFF7, 32'd0, 1, 0, 1'b1};
`else
      vecs[9]  = '{"divu_9_0", 2'b11, 32'd9, 32'd0,
                   32'd9, 32'hFFFFFFFF, 34, 33, 1'b0};
      vecs[10] = '{"div_m9_0", 2'b10, 32'hFFFFFFF7, 32'd0,
                   32'hFFFFFFF7, 32'd1, 34, 33, 1'b0};
`endif

      reset = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      flush = 1'b0; op = 2'b00; srca = '0; srcb = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", dz, 0);

      // table-driven vectors
      foreach (vecs[k]) begin
         @(negedge clk);
         run(vecs[k].op, vecs[k].a, vecs[k].b, -5, 1'b0, 1'b1,
             at, bn, dn, rh, rl, rz);
         chk({vecs[k].nm, "_lat"}, at, vecs[k].lat);
         chk({vecs[k].nm, "_busy"}, bn, vecs[k].busy_n);
         chk({vecs[k].nm, "_hi"}, rh, vecs[k].hi);
         chk({vecs[k].nm, "_lo"}, rl, vecs[k].lo);
         chk({vecs[k].nm, "_dz"}, rz, vecs[k].dz);
      end

      // back-to-back: DIV launched in the MULT done cycle
      @(negedge clk);
      run(2'b00, 32'hFFFFFFF9, 32'd3, -5, 1'b0, 1'b1, at, bn, dn, rh, rl, rz);
      chk("b2b_mult_lat", at, 34);
      chk("b2b_mult_hi", rh, 32'hFFFFFFFF);
      chk("b2b_mult_lo", rl, 32'hFFFFFFEB);
      run(2'b10, 32'hFFFFFFF9, 32'd2, -5, 1'b0, 1'b1, at, bn, dn, rh, rl, rz);
      chk("b2b_div_lat", at, 34);
      chk("b2b_div_hi", rh, 32'hFFFFFFFF);
      chk("b2b_div_lo", rl, 32'hFFFFFFFD);

      // start while busy is ignored
      @(negedge clk);
      run(2'b11, 32'd100, 32'd7, 10, 1'b0, 1'b0, at, bn, dn, rh, rl, rz);
      chk("ign_lat", at, 34);
      chk("ign_dones", dn, 1);
      chk("ign_hi", hi, 32'd2);
      chk("ign_lo", lo, 32'd14);

      // flush mid-operation
      @(negedge clk);
      run(2'b00, 32'd5, 32'd5, 10, 1'b1, 1'b0, at, bn, dn, rh, rl, rz);
      chk("flush_dones", dn, 0);
      chk("flush_busy_n", bn, 10);
      chk("flush_hi", hi, 32'd2);
      chk("flush_lo", lo, 32'd14);

      // MTHI in idle
      @(negedge clk);
      wr_hi = 1'b1; srca = 32'h1234;
      @(posedge clk); #1;
      wr_hi = 1'b0;
      chk("mthi_hi", hi, 32'h1234);
      chk("mthi_lo", lo, 32'd14);

      // MTLO while busy is ignored
      @(negedge clk);
      op = 2'b00; srca = 32'd5; srcb = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 wr_lo = 1'b1; srca = 32'hDEAD;
      @(posedge clk); #1;
      wr_lo = 1'b0;
      chk("mtlo_busy_lo", lo, 32'd14);
      at = -1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) begin at = i; break; end
      end
      chk("mult55_done", at >= 0, 1);
      chk("mult55_lo", lo, 32'd25);
      chk("mult55_hi", hi, 32'd0);

      // start and MTHI in the same cycle: start wins
      @(negedge clk);
      op = 2'b01; srca = 32'd2; srcb = 32'd3; start = 1'b1; wr_hi = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; wr_hi = 1'b0;
      chk("stwr_hi", hi, 32'd0);
      chk("stwr_busy", busy, 1);
      at = -1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) begin at = i; break; end
      end
      chk("stwr_done", at >= 0, 1);
      chk("stwr_lo", lo, 32'd6);

      // flush and start in the same cycle: nothing launched
      @(negedge clk);
      op = 2'b00; srca = 32'd7; srcb = 32'd7; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("fs_busy", busy, 0);
      count_done(40, dn);
      chk("fs_dones", dn, 0);
      chk("fs_lo", lo, 32'd6);

      // reset mid-operation
      @(negedge clk);
      op = 2'b00; srca = 32'd9; srcb = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rmid_hi", hi, 0);
      chk("rmid_lo", lo, 0);
      chk("rmid_busy", busy, 0);
      count_done(40, dn);
      chk("rmid_dones", dn, 0);
      chk("rmid_lo_after", lo, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative multiply/divide sequencer for the pipelined MIPS core. It owns the HI/LO registers and executes MULT, MULTU, DIV and DIVU over multiple cycles. It raises busy so the hazard unit stalls any MFHI/MFLO or new mul/div. It sits beside the ALU in the EX stage, fed by the main decoder, and runs independently of ALU operations.

Parameters:
WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  launch operation (EX stage, not stalled)
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srca  in  WIDTH  rs operand (multiplicand/dividend); also MTHI/MTLO data
srcb  in  WIDTH  rt operand (multiplier/divisor)
wr_hi  in  1  MTHI: HI <= srca
wr_lo  in  1  MTLO: LO <= srca
flush  in  1  cancel in-flight operation
busy  out  1  operation in progress
done  out  1  one-cycle pulse when HI/LO hold a new result
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts the operation and leaves no partial HI/LO update.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE: start=1 latches op and the operands and enters CALC.
  - Signed ops convert the operands to magnitudes and record the result signs: quotient/product sign = sign(a) XOR sign(b); remainder sign = sign(a).
- CALC: exactly WIDTH cycles; counter runs 0..WIDTH-1.
  - Multiply: shift-add, producing a 2*WIDTH-bit product.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- FIX: applies two's-complement sign correction, then writes HI/LO:
  - multiply: HI = product upper half, LO = product lower half;
  - divide: LO = quotient, HI = remainder.
- Timing: start sampled at edge N.
  - busy=1 during cycles N+1 .. N+WIDTH+1.
  - HI/LO update and done=1 in cycle N+WIDTH+2 (34 cycles for WIDTH=32).
  - busy=0 in the done cycle.
- start while busy is ignored.
- A start in the done cycle is accepted; back-to-back ops have no bubble.
- wr_hi/wr_lo act only in IDLE with start=0 and take effect on the next edge.
  - Ignored while busy.
  - If start is in the same cycle, start wins and the write is dropped.
- flush: in any state, next state is IDLE, busy=0, no done, HI/LO unchanged.
  - flush with start in the same cycle: flush wins and nothing is launched.
- Arithmetic:
  - Signed -2^(W-1) operands are handled via magnitude W bits wide, unsigned.
  - MULT/MULTU results are the exact 2W-bit product.
  - Division truncates toward zero; the remainder takes the dividend's sign.
  - DIV of 0x80000000 by -1 gives LO=0x80000000, HI=0 (natural wrap).
- Divide by zero (without the optional feature): runs the full WIDTH cycles with the restoring-algorithm result.
  - DIVU: LO=all-ones, HI=dividend.
  - DIV: LO=0xFFFFFFFF if dividend >= 0, else 0x00000001; HI=dividend.

Optional Feature:
MULDIV_DIVZERO_EN
- Defined:
  - Adds output port divzero (1 bit, reset 0).
  - DIV/DIVU with srcb==0 skips CALC and FIX: done pulses in cycle N+1 with HI=srca, LO=0, and divzero=1 for that same cycle; busy stays 0.
  - divzero is low in every other cycle.
- Undefined: no divzero port; divide by zero behaves as specified under Behaviour.

Test Plan:
- Reset, then idle -> hi=0, lo=0, busy=0, done=0.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at start+34: hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then a back-to-back DIV -7 / 2 started in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done at +34.
- DIVU 100 / 7 -> lo=14, hi=2. A second start mid-operation is ignored: exactly one done pulse, values unchanged.
- MULT 5 x 5, flush at start+10 -> no done pulse; hi/lo keep prior values. Then wr_hi with srca=0x1234 -> hi=0x1234 next cycle. wr_lo while busy -> lo unchanged.
- DIVU 9 / 0:
  - without macro -> done at +34, lo=0xFFFFFFFF, hi=9;
  - with MULDIV_DIVZERO_EN -> done and divzero at +1, hi=9, lo=0.
